// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: width arithmetic and
// parameter legality checks used at elaboration time.
package fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit width_ok(input int width);
        return width >= 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_level_ok(input int af_level, input int depth);
        return (af_level >= 1) && (af_level <= depth);
    endfunction

    function automatic bit ae_level_ok(input int ae_level, input int depth);
        return (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array, synchronous write port and registered
// read port; the only storage in the FIFO, swappable for a RAM macro.
module fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage itself is never reset; contents after a flush are don't-care.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with independent write/read enables,
// occupancy count, threshold flags, flush and overflow/underflow pulses.
module param_fifo
    import fifo_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = DEPTH - 1,
    parameter  int AE_LEVEL = 1,
    localparam int CW       = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] out_o,
    output logic             rd_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int AW = clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("param_fifo: WIDTH must be >= 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of two >= 2");
    end
    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
        $error("param_fifo: AF_LEVEL must be in 1..DEPTH");
    end
    if (!ae_level_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae
        $error("param_fifo: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, af_q, ae_q;
    logic          rd_valid_q, ovf_q, udf_q;
    logic          flush;
    logic          wa, ra;

    // Flush (reset or clr) swallows any request in the same cycle.
    assign flush = rst_i | clr_i;
    assign wa    = wr_en_i & ~full_q  & ~flush;
    assign ra    = rd_en_i & ~empty_q & ~flush;

    always_comb begin
        count_d = count_q + CW'(wa) - CW'(ra);
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wp_q       <= wp_q + AW'(wa);
            rp_q       <= rp_q + AW'(ra);
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            af_q       <= (count_d >= AF_C);
            ae_q       <= (count_d <= AE_C);
            rd_valid_q <= ra;
            ovf_q      <= wr_en_i & full_q;
            udf_q      <= rd_en_i & empty_q;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (flush),
        .we_i    (wa),
        .waddr_i (wp_q),
        .wdata_i (in_i),
        .re_i    (ra),
        .raddr_i (rp_q),
        .rdata_o (out_o)
    );

    assign rd_valid_o     = rd_valid_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_param_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = DEPTH - 1;
    localparam int AEL   = 1;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             rd_valid, full, empty, afull, aempty, ovf, udf;
    logic [CW-1:0]    count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_out;
    logic             m_rv, m_ovf, m_udf;

    always #5 clk = ~clk;

    param_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clr_i          (clr),
        .wr_en_i        (wr_en),
        .in_i           (din),
        .rd_en_i        (rd_en),
        .out_o          (dout),
        .rd_valid_o     (rd_valid),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .count_o        (count),
        .overflow_o     (ovf),
        .underflow_o    (udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},  32'(count),    32'(n));
        chk({tag, ".full"},   32'(full),     32'(n == DEPTH));
        chk({tag, ".empty"},  32'(empty),    32'(n == 0));
        chk({tag, ".afull"},  32'(afull),    32'(n >= AFL));
        chk({tag, ".aempty"}, 32'(aempty),   32'(n <= AEL));
        chk({tag, ".rvalid"}, 32'(rd_valid), 32'(m_rv));
        chk({tag, ".out"},    32'(dout),     32'(m_out));
        chk({tag, ".ovf"},    32'(ovf),      32'(m_ovf));
        chk({tag, ".udf"},    32'(udf),      32'(m_udf));
    endtask

    // One clock: drive, update the model on the edge, check just after it.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [WIDTH-1:0] d, input logic c, input logic rs);
        bit was_full, was_empty;
        wr_en = w; rd_en = r; din = d; clr = c; rst = rs;
        @(posedge clk);
        if (rs || c) begin
            q.delete();
            m_out = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_ovf = w && was_full;
            m_udf = r && was_empty;
            m_rv  = r && !was_empty;
            if (m_rv) m_out = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
        #1;
        check_all(tag);
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        m_out = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        #2;
        step("reset", 0, 0, 8'h00, 0, 1);
        step("reset_hold", 0, 0, 8'h00, 0, 1);
        step("idle", 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 3; i++) step("pre_clr_wr", 1, 0, 8'(8'h50 + i), 0, 0);
        step("pre_clr_rd", 0, 1, 8'h00, 0, 0);
        step("clr", 1, 1, 8'hEE, 1, 0);

        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 8'(i), 0, 0);
        step("overflow", 1, 0, 8'h99, 0, 0);
        step("ovf_drop", 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 8'h00, 0, 0);
        step("underflow", 0, 1, 8'h00, 0, 0);
        step("udf_drop", 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 4; i++) step("fill4", 1, 0, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 20; i++) step("stream", 1, 1, 8'(8'h30 + i), 0, 0);

        for (int i = 0; i < 8 && q.size() < DEPTH; i++) step("to_full", 1, 0, 8'(8'h60 + i), 0, 0);
        step("both_full", 1, 1, 8'hA5, 0, 0);
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step("to_empty", 0, 1, 8'h00, 0, 0);
        step("both_empty", 1, 1, 8'h5A, 0, 0);
        step("after_empty", 0, 1, 8'h00, 0, 0);

        for (int i = 0; i < 5; i++) step("mid_fill", 1, 0, 8'(8'h70 + i), 0, 0);
        step("mid_rst", 1, 1, 8'hFF, 0, 1);
        step("post_rst_wr", 1, 0, 8'hAA, 0, 0);
        step("post_rst_rd", 0, 1, 8'h00, 0, 0);

        for (int ph = 0; ph < 3; ph++) begin
            int pw, pr;
            pw = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            pr = (ph == 0) ? 30 : (ph == 1) ? 70 : 50;
            for (int i = 0; i < 1000; i++) begin
                logic w, r, c, rs;
                w  = ($urandom_range(0, 99) < pw);
                r  = ($urandom_range(0, 99) < pr);
                c  = ($urandom_range(0, 199) == 0);
                rs = ($urandom_range(0, 299) == 0);
                step("rand", w, r, 8'($urandom), c, rs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
